// File: rtl/ex_muldiv_seq_pkg.sv
// ex_pkg: shared encodings for the EX-stage sequential multiply/divide unit.
//   alu_op_e  - ALU operation select (ADD/SUB drive the MDU iterations)
//   mdu_op_e  - MDU operation select carried on i_mdu_op
//   state_e   - MDU control FSM states
package ex_pkg;

  localparam int XLEN   = 32;
  localparam int ITERS  = 32;
  localparam int CNT_W  = 5;

  typedef enum logic [3:0] {
    ALU_ADD = 4'b0000,
    ALU_SUB = 4'b0001,
    ALU_AND = 4'b0010,
    ALU_OR  = 4'b0011,
    ALU_XOR = 4'b0100
  } alu_op_e;

  typedef enum logic [1:0] {
    MDU_MUL  = 2'b00,
    MDU_DIVU = 2'b01,
    MDU_REMU = 2'b10,
    MDU_RSVD = 2'b11
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/ex_muldiv_seq_if.sv
// ex_muldiv_seq_if: request/response bundle between the EX stage and the MDU.
//   i_start/i_mdu_op/i_operand_a/i_operand_b - operation request
//   i_flush                                  - pipeline kill
//   o_busy/o_valid/o_mdu_data                - status and result
//   master: EX-stage side, slave: MDU side.
interface ex_muldiv_seq_if;
  import ex_pkg::*;

  logic            i_start;
  logic [1:0]      i_mdu_op;
  logic [XLEN-1:0] i_operand_a;
  logic [XLEN-1:0] i_operand_b;
  logic            i_flush;
  logic            o_busy;
  logic            o_valid;
  logic [XLEN-1:0] o_mdu_data;

  modport master (
    output i_start, i_mdu_op, i_operand_a, i_operand_b, i_flush,
    input  o_busy, o_valid, o_mdu_data
  );

  modport slave (
    input  i_start, i_mdu_op, i_operand_a, i_operand_b, i_flush,
    output o_busy, o_valid, o_mdu_data
  );

endinterface

// File: rtl/ex_muldiv_seq_alu.sv
// alu: combinational 32-bit ALU slice shared with the MDU iteration path.
//   i_op - operation (alu_op_e)
//   i_a  - operand A
//   i_b  - operand B
//   o_y  - result
module alu
  import ex_pkg::*;
(
  input  alu_op_e         i_op,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  output logic [XLEN-1:0] o_y
);

  always_comb begin
    o_y = '0;
    case (i_op)
      ALU_ADD: o_y = i_a + i_b;
      ALU_SUB: o_y = i_a - i_b;
      ALU_AND: o_y = i_a & i_b;
      ALU_OR:  o_y = i_a | i_b;
      ALU_XOR: o_y = i_a ^ i_b;
      default: o_y = '0;
    endcase
  end

endmodule

// File: rtl/ex_muldiv_seq.sv
// ex_muldiv_seq: iterative 32-bit MUL (low word) / DIVU / REMU unit.
//   i_clk - clock, rising edge
//   i_rst - asynchronous active-high reset
//   mdu   - ex_muldiv_seq_if.slave: start/op/operands/flush in,
//           busy/valid/result out
// One shift-add or restoring-divide step per cycle for 32 cycles, then a
// single DONE cycle that pulses o_valid. Divide by zero skips straight to
// DONE with the RISC-V defined result.
module ex_muldiv_seq
  import ex_pkg::*;
(
  input  logic      i_clk,
  input  logic      i_rst,
  ex_muldiv_seq_if.slave mdu
);

  state_e          state_q, state_d;
  mdu_op_e         op_q;
  logic [XLEN-1:0] mcand_q, mplier_q, acc_q;
  logic [XLEN-1:0] quot_q, div_q, rem_q;
  logic [CNT_W-1:0] cnt_q;
  logic [XLEN-1:0] data_q;

  logic            start_ok, div_zero, is_mul, last;
  logic [XLEN:0]   rem_sh;
  logic            borrow_lo, no_borrow;
  alu_op_e         alu_op;
  logic [XLEN-1:0] alu_a, alu_b, alu_y;
  logic [XLEN-1:0] acc_n, quot_n, rem_n, res_n;

  // Flush beats start; the reserved op never leaves IDLE.
  assign start_ok = (state_q == ST_IDLE) && mdu.i_start && !mdu.i_flush &&
                    (mdu.i_mdu_op != MDU_RSVD);
  assign div_zero = (mdu.i_mdu_op != MDU_MUL) && (mdu.i_operand_b == '0);
  assign is_mul   = (op_q == MDU_MUL);
  assign last     = (cnt_q == CNT_W'(ITERS - 1));

  // Single ALU: ADD for the multiply accumulate, SUB for the divide trial.
  assign rem_sh = {rem_q, quot_q[XLEN-1]};
  assign alu_op = is_mul ? ALU_ADD : ALU_SUB;
  assign alu_a  = is_mul ? acc_q   : rem_sh[XLEN-1:0];
  assign alu_b  = is_mul ? mcand_q : div_q;

  alu u_alu (
    .i_op (alu_op),
    .i_a  (alu_a),
    .i_b  (alu_b),
    .o_y  (alu_y)
  );

  // 33-bit trial = rem_sh - {0,div}: the low word comes from the ALU and the
  // top bit only decides the borrow. When the trial is kept it is < divisor,
  // so its bit 32 is always zero and the remainder fits in 32 bits.
  assign borrow_lo = (rem_sh[XLEN-1:0] < div_q);
  assign no_borrow = rem_sh[XLEN] | ~borrow_lo;

  assign acc_n  = mplier_q[0] ? alu_y : acc_q;
  assign rem_n  = no_borrow ? alu_y : rem_sh[XLEN-1:0];
  assign quot_n = {quot_q[XLEN-2:0], no_borrow};

  always_comb begin
    res_n = rem_n;
    case (op_q)
      MDU_MUL:  res_n = acc_n;
      MDU_DIVU: res_n = quot_n;
      default:  res_n = rem_n;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start_ok) state_d = div_zero ? ST_DONE : ST_RUN;
      ST_RUN:  if (last)     state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (mdu.i_flush) state_d = ST_IDLE;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      op_q     <= MDU_MUL;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      quot_q   <= '0;
      div_q    <= '0;
      rem_q    <= '0;
      cnt_q    <= '0;
      data_q   <= '0;
    end else if (start_ok) begin
      op_q     <= mdu_op_e'(mdu.i_mdu_op);
      mcand_q  <= mdu.i_operand_a;
      mplier_q <= mdu.i_operand_b;
      quot_q   <= mdu.i_operand_a;
      div_q    <= mdu.i_operand_b;
      acc_q    <= '0;
      rem_q    <= '0;
      cnt_q    <= '0;
      if (div_zero)
        data_q <= (mdu.i_mdu_op == MDU_DIVU) ? '1 : mdu.i_operand_a;
    end else if (state_q == ST_RUN && !mdu.i_flush) begin
      acc_q    <= acc_n;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      rem_q    <= rem_n;
      quot_q   <= quot_n;
      cnt_q    <= cnt_q + CNT_W'(1);
      if (last) data_q <= res_n;
    end
  end

  assign mdu.o_busy     = (state_q != ST_IDLE);
  assign mdu.o_valid    = (state_q == ST_DONE) && !mdu.i_flush;
  assign mdu.o_mdu_data = data_q;

endmodule

// File: tb/tb_ex_muldiv_seq.sv
module tb_ex_muldiv_seq;
  import ex_pkg::*;

  logic i_clk = 1'b0;
  logic i_rst = 1'b1;
  int   n_asserts = 0;
  int   n_fail = 0;
  logic [31:0] last_data = '0;

  ex_muldiv_seq_if mif();

  ex_muldiv_seq dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .mdu   (mif)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // RISC-V M semantics written directly with plain arithmetic.
  function automatic logic [31:0] ref_model(input logic [1:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    logic [63:0] p;
    case (op)
      2'b00: begin p = {32'd0, a} * {32'd0, b}; ref_model = p[31:0]; end
      2'b01: ref_model = (b == 0) ? 32'hFFFF_FFFF : a / b;
      default: ref_model = (b == 0) ? a : a % b;
    endcase
  endfunction

  // Present one request in the current cycle, scramble inputs afterwards,
  // poke an ignored start mid-run, and check latency, busy, result and hold.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input string tag);
    logic [31:0] exp;
    int lat, k;
    logic got, busy_ok;
    exp = ref_model(op, a, b);
    lat = (op != 2'b00 && b == 0) ? 1 : 33;
    mif.i_start = 1'b1; mif.i_mdu_op = op; mif.i_operand_a = a; mif.i_operand_b = b;
    k = 0; got = 1'b0; busy_ok = 1'b1;
    while (!got && k < 40) begin
      @(posedge i_clk); #1; k++;
      if (k == 1 || k == 6) begin
        mif.i_start = 1'b0;
        mif.i_operand_a = $urandom; mif.i_operand_b = $urandom;
        mif.i_mdu_op = 2'($urandom_range(0, 3));
      end
      if (k == 5) mif.i_start = 1'b1;
      if (mif.o_busy !== 1'b1) busy_ok = 1'b0;
      if (mif.o_valid === 1'b1) got = 1'b1;
    end
    mif.i_start = 1'b0;
    check({tag, "_valid"}, 32'(got), 32'd1);
    check({tag, "_lat"}, k, lat);
    check({tag, "_data"}, mif.o_mdu_data, exp);
    check({tag, "_busy"}, 32'(busy_ok), 32'd1);
    @(posedge i_clk); #1;
    check({tag, "_vld_off"}, 32'(mif.o_valid), 32'd0);
    check({tag, "_busy_off"}, 32'(mif.o_busy), 32'd0);
    check({tag, "_hold"}, mif.o_mdu_data, exp);
    last_data = exp;
  endtask

  // Watch n cycles in which nothing may start.
  task automatic expect_quiet(input int n, input string tag);
    logic vld_seen, busy_seen;
    vld_seen = 1'b0; busy_seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge i_clk); #1;
      mif.i_start = 1'b0; mif.i_flush = 1'b0;
      if (mif.o_valid !== 1'b0) vld_seen = 1'b1;
      if (mif.o_busy !== 1'b0) busy_seen = 1'b1;
    end
    check({tag, "_no_valid"}, 32'(vld_seen), 32'd0);
    check({tag, "_no_busy"}, 32'(busy_seen), 32'd0);
    check({tag, "_data"}, mif.o_mdu_data, last_data);
  endtask

  initial begin
    logic [1:0] rop;
    logic [31:0] ra, rb;
    logic vld_seen;
    mif.i_start = 1'b0; mif.i_mdu_op = 2'b00; mif.i_operand_a = '0;
    mif.i_operand_b = '0; mif.i_flush = 1'b0;

    // Reset state
    repeat (2) @(posedge i_clk);
    #1;
    check("rst_busy", 32'(mif.o_busy), 32'd0);
    check("rst_valid", 32'(mif.o_valid), 32'd0);
    check("rst_data", mif.o_mdu_data, 32'd0);
    i_rst = 1'b0;

    // Directed operations
    run_op(2'b00, 32'd7, 32'd6, "mul_7x6");
    run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mul_ffxff");
    run_op(2'b00, 32'h8000_0000, 32'd2, "mul_ovf");
    run_op(2'b01, 32'd100, 32'd7, "divu_100_7");
    run_op(2'b10, 32'd100, 32'd7, "remu_100_7");
    run_op(2'b01, 32'hFFFF_FFFF, 32'd1, "divu_max_1");
    run_op(2'b10, 32'd5, 32'hFFFF_FFFF, "remu_5_max");
    run_op(2'b01, 32'd9, 32'd0, "divu_by0");
    run_op(2'b10, 32'd5, 32'd0, "remu_by0");

    // Reserved op is ignored
    mif.i_start = 1'b1; mif.i_mdu_op = 2'b11; mif.i_operand_a = 32'd3; mif.i_operand_b = 32'd4;
    expect_quiet(40, "op11");

    // Flush and start together in IDLE
    mif.i_start = 1'b1; mif.i_flush = 1'b1; mif.i_mdu_op = 2'b00;
    mif.i_operand_a = 32'd5; mif.i_operand_b = 32'd5;
    expect_quiet(40, "flush_start");

    // Flush during RUN at iteration 10, then an immediate new MUL
    mif.i_start = 1'b1; mif.i_mdu_op = 2'b00;
    mif.i_operand_a = 32'h1234; mif.i_operand_b = 32'h5678;
    vld_seen = 1'b0;
    for (int k = 1; k <= 11; k++) begin
      @(posedge i_clk); #1;
      mif.i_start = 1'b0;
      if (mif.o_valid !== 1'b0) vld_seen = 1'b1;
    end
    mif.i_flush = 1'b1;
    #2;
    check("flush_vld_gate", 32'(mif.o_valid), 32'd0);
    @(posedge i_clk); #1;
    mif.i_flush = 1'b0;
    check("flush_busy", 32'(mif.o_busy), 32'd0);
    check("flush_no_valid", 32'(vld_seen | mif.o_valid), 32'd0);
    check("flush_data", mif.o_mdu_data, last_data);
    run_op(2'b00, 32'd3, 32'd3, "mul_after_flush");

    // Asynchronous reset mid-RUN, then a normal restart
    mif.i_start = 1'b1; mif.i_mdu_op = 2'b00;
    mif.i_operand_a = 32'd11; mif.i_operand_b = 32'd13;
    for (int k = 1; k <= 10; k++) begin
      @(posedge i_clk); #1;
      mif.i_start = 1'b0;
    end
    check("pre_rst_busy", 32'(mif.o_busy), 32'd1);
    #3;
    i_rst = 1'b1;
    #1;
    check("arst_busy", 32'(mif.o_busy), 32'd0);
    check("arst_valid", 32'(mif.o_valid), 32'd0);
    check("arst_data", mif.o_mdu_data, 32'd0);
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    last_data = '0;
    run_op(2'b01, 32'd1000, 32'd33, "divu_after_rst");

    // Randomized operations against the reference model
    for (int i = 0; i < 30; i++) begin
      rop = 2'($urandom_range(0, 2));
      ra = $urandom;
      if ($urandom_range(0, 7) == 0) rb = 32'd0;
      else if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 20));
      else rb = $urandom;
      run_op(rop, ra, rb, $sformatf("rand%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
